// File: rtl/joint_cmd_ramp.sv
// Slew-limited joint frequency command feeding the pwmdir driver; forces a zero tick on sign change.
// Optional command watchdog enabled by defining JOINT_CMD_WDOG_EN.
module joint_cmd_ramp #(
    parameter int RAMP_DIV    = 1000,
    parameter int ACCEL_STEP  = 10,
    parameter int CMD_MAX     = 100000,
    parameter int WDOG_CYCLES = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               jointEnable,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic signed [31:0] cmd_target,
    output logic signed [31:0] jointFreqCmd,
    output logic               at_target,
    output logic               wdog_tripped
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic signed [32:0] STEP = 33'(ACCEL_STEP);
    localparam logic signed [31:0] LIM  = 32'(CMD_MAX);

    typedef enum logic [1:0] {IDLE, HOLD, RAMP, STOP} state_t;

    state_t             state, state_next;
    logic [PW-1:0]      presc;
    logic signed [31:0] target, target_next, out_next, goal;
    logic               at_target_next, tick, accept, tripped, trip_now;

    function automatic logic signed [31:0] clamp_cmd(input logic signed [31:0] v);
        if (v > LIM)
            return LIM;
        else if (v < -LIM)
            return -LIM;
        return v;
    endfunction

    // One slew step in 33 bits; a step that would jump across zero lands on zero instead.
    function automatic logic signed [31:0] ramp_step(input logic signed [31:0] cur,
                                                     input logic signed [31:0] dst);
        logic signed [32:0] c, d, diff, nxt;
        c    = $signed({cur[31], cur});
        d    = $signed({dst[31], dst});
        diff = d - c;
        if (diff > STEP)
            nxt = c + STEP;
        else if (diff < -STEP)
            nxt = c - STEP;
        else
            nxt = d;
        if ((c > 33'sd0 && nxt < 33'sd0) || (c < 33'sd0 && nxt > 33'sd0))
            nxt = 33'sd0;
        return nxt[31:0];
    endfunction

    assign cmd_ready    = !rst && !tripped;
    assign accept       = cmd_valid && cmd_ready;
    assign tick         = (state != IDLE) && (presc == PRESC_LAST);
    assign wdog_tripped = tripped;

`ifdef JOINT_CMD_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt;

    assign trip_now = jointEnable && !tripped && !accept && (wdog_cnt == WW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !jointEnable) begin
            wdog_cnt <= '0;
            tripped  <= 1'b0;
        end else if (accept) begin
            wdog_cnt <= '0;
        end else if (trip_now) begin
            wdog_cnt <= '0;
            tripped  <= 1'b1;
        end else if (!tripped) begin
            wdog_cnt <= wdog_cnt + WW'(1);
        end
    end
`else
    assign tripped  = 1'b0;
    assign trip_now = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        target_next = target;
        out_next    = jointFreqCmd;
        goal        = (state == RAMP && jointEnable) ? target : '0;
        if (accept)
            target_next = clamp_cmd(cmd_target);
        if (trip_now)
            target_next = '0;
        if (tick && (state == RAMP || state == STOP))
            out_next = ramp_step(jointFreqCmd, goal);
        case (state)
            IDLE: begin
                out_next = '0;
                if (jointEnable && !tripped && !trip_now)
                    state_next = HOLD;
            end
            HOLD: begin
                if (!jointEnable || trip_now)
                    state_next = STOP;
                else if (target != jointFreqCmd)
                    state_next = RAMP;
            end
            RAMP: begin
                if (!jointEnable || trip_now)
                    state_next = STOP;
                else if (tick && out_next == target)
                    state_next = HOLD;
            end
            STOP: begin
                if (jointEnable && !tripped && !trip_now)
                    state_next = RAMP;
                else if (jointFreqCmd == '0)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        at_target_next = (state_next == HOLD) || (state_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            presc        <= '0;
            target       <= '0;
            jointFreqCmd <= '0;
            at_target    <= 1'b1;
        end else begin
            state        <= state_next;
            target       <= target_next;
            jointFreqCmd <= out_next;
            at_target    <= at_target_next;
            if (state == IDLE || state_next == IDLE || tick)
                presc <= '0;
            else
                presc <= presc + PW'(1);
        end
    end

endmodule

// File: tb/tb_joint_cmd_ramp.sv
// Directed bench for joint_cmd_ramp: ramp, zero crossing, clamp, disable, reset and watchdog.
module tb_joint_cmd_ramp;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               jointEnable = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic signed [31:0] cmd_target = '0;
    logic signed [31:0] jointFreqCmd;
    logic               at_target;
    logic               wdog_tripped;

    int total = 0;
    int bad   = 0;
    logic signed [31:0] last_out = '0;

    joint_cmd_ramp #(
        .RAMP_DIV(4),
        .ACCEL_STEP(10),
        .CMD_MAX(100),
        .WDOG_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .jointEnable(jointEnable),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_target(cmd_target),
        .jointFreqCmd(jointFreqCmd),
        .at_target(at_target),
        .wdog_tripped(wdog_tripped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the output to change, then check its value and the cycles it took.
    task automatic step_to(input string tag, input int value, input int gap);
        int n = 0;
        while (n < 12) begin
            @(negedge clk);
            n++;
            if (jointFreqCmd !== last_out) break;
        end
        check(tag, jointFreqCmd, value);
        if (gap != 0)
            check({tag, "_gap"}, n, gap);
        else
            check({tag, "_gap"}, 32'(n <= 4), 1);
        last_out = jointFreqCmd;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out", jointFreqCmd, 0);
        check("rst_at", at_target, 1);
        check("rst_wdog", wdog_tripped, 0);
        check("rst_ready", cmd_ready, 0);
        last_out = '0;

        // ramp up to 35
        rst = 1'b0;
        jointEnable = 1'b1;
        cmd_valid = 1'b1;
        cmd_target = 35;
        step_to("up10", 10, 5);
        check("up10_at", at_target, 0);
        step_to("up20", 20, 4);
        step_to("up30", 30, 4);
        check("up30_at", at_target, 0);
        step_to("up35", 35, 4);
        check("up35_at", at_target, 1);
        check("ready", cmd_ready, 1);

        // zero crossing to -15
        cmd_target = -15;
        step_to("zc25", 25, 4);
        step_to("zc15", 15, 4);
        step_to("zc5", 5, 4);
        step_to("zc0", 0, 4);
        check("zc0_at", at_target, 0);
        step_to("zcm10", -10, 4);
        step_to("zcm15", -15, 4);
        check("zcm15_at", at_target, 1);

        // ramp toward 80, disable at 30
        cmd_target = 80;
        step_to("d_m5", -5, 4);
        step_to("d_0", 0, 4);
        step_to("d_10", 10, 4);
        step_to("d_20", 20, 4);
        step_to("d_30", 30, 4);
        jointEnable = 1'b0;
        step_to("stop20", 20, 4);
        check("stop20_at", at_target, 0);
        cmd_target = 50;
        step_to("stop10", 10, 4);
        step_to("stop0", 0, 4);
        repeat (2) @(negedge clk);
        check("idle_at", at_target, 1);
        check("idle_out", jointFreqCmd, 0);
        jointEnable = 1'b1;
        step_to("re10", 10, 5);
        step_to("re20", 20, 4);
        step_to("re30", 30, 4);
        step_to("re40", 40, 4);
        step_to("re50", 50, 4);
        check("re50_at", at_target, 1);

        // clamp both directions
        cmd_target = 200;
        for (int v = 60; v <= 100; v += 10) step_to("clamp_hi", v, 4);
        check("clamp_hi_at", at_target, 1);
        cmd_target = 32'sh8000_0000;
        for (int v = 90; v >= -100; v -= 10) step_to("clamp_lo", v, 4);
        check("clamp_lo_at", at_target, 1);

        // reset mid-ramp at 20, command during reset ignored
        cmd_target = 100;
        for (int v = -90; v <= 20; v += 10) step_to("pre_rst", v, 4);
        rst = 1'b1;
        cmd_target = 77;
        @(negedge clk);
        check("mid_rst_out", jointFreqCmd, 0);
        check("mid_rst_at", at_target, 1);
        check("mid_rst_ready", cmd_ready, 0);
        rst = 1'b0;
        cmd_valid = 1'b0;
        last_out = '0;
        repeat (12) @(negedge clk);
        check("post_rst_out", jointFreqCmd, 0);
        check("post_rst_at", at_target, 1);

`ifdef JOINT_CMD_WDOG_EN
        begin
            int n = 0;
            cmd_valid = 1'b1;
            cmd_target = 30;
            @(negedge clk);
            cmd_valid = 1'b0;
            while (!wdog_tripped && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("wd_cycles", n, 50);
            check("wd_out", jointFreqCmd, 30);
            check("wd_ready", cmd_ready, 0);
            last_out = 30;
            step_to("wd20", 20, 0);
            step_to("wd10", 10, 4);
            step_to("wd0", 0, 4);
            repeat (2) @(negedge clk);
            check("wd_sticky", wdog_tripped, 1);
            check("wd_sticky_ready", cmd_ready, 0);
            check("wd_idle_at", at_target, 1);
            jointEnable = 1'b0;
            @(negedge clk);
            check("wd_clear", wdog_tripped, 0);
            check("wd_clear_ready", cmd_ready, 1);
            jointEnable = 1'b1;
            repeat (8) @(negedge clk);
            check("wd_target0", jointFreqCmd, 0);
            check("wd_target0_at", at_target, 1);
        end
`else
        repeat (60) @(negedge clk);
        check("nowd_flag", wdog_tripped, 0);
        check("nowd_ready", cmd_ready, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
